// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared sizes and loader state encodings for the instruction-memory loader
package imem_loader_pkg;
  localparam int IMEM_ADDR_W = 6;
  localparam int IMEM_DEPTH  = 64;
  typedef enum logic [2:0] {
    LD_IDLE,
    LD_COUNT,
    LD_DATA,
    LD_CHECK,
    LD_DONE,
    LD_ERR
  } ld_state_e;
endpackage

// File: rtl/imem_loader_word_assembler.sv
// imem_loader_word_assembler: shifts stream bytes into little-endian 32-bit words
module imem_loader_word_assembler (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        en,
  input  logic [7:0]  din,
  output logic [31:0] word,
  output logic        word_ready
);
  logic [1:0]  idx_q, idx_d;
  logic [23:0] buf_q, buf_d;
  // Lanes 0..2 are buffered; lane 3 is the live byte, so the word is complete in the accepting cycle.
  always_comb begin
    idx_d = clr ? 2'd0 : en ? idx_q + 2'd1 : idx_q;
    buf_d = buf_q;
    if (en && idx_q != 2'd3) buf_d[8*idx_q +: 8] = din;
  end
  // Byte index and lane buffer; reset drops any partial word.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q <= '0;
      buf_q <= '0;
    end else begin
      idx_q <= idx_d;
      buf_q <= buf_d;
    end
  end
  assign word       = {din, buf_q};
  assign word_ready = en && idx_q == 2'd3;
endmodule

// File: rtl/imem_loader.sv
// imem_loader: framed byte-stream programmer for the instruction memory (optional IMEM_LOADER_CHECKSUM_EN adds a trailing XOR byte)
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W = IMEM_ADDR_W,
  parameter int DEPTH  = IMEM_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              error
);
  ld_state_e         state_q, state_d;
  logic [ADDR_W:0]   cnt_q, cnt_d, widx_q, widx_d;
  logic              mem_we_q, mem_we_d, hold_q, hold_d, done_q, done_d, err_q, err_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d, word;
  logic              xfer, bad_cnt, last_word, word_ready;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]        chk_q, chk_d;
`endif

  assign in_ready  = state_q inside {LD_COUNT, LD_DATA, LD_CHECK};
  assign xfer      = in_valid && in_ready;
  assign bad_cnt   = in_data == 8'd0 || 32'(in_data) > DEPTH;
  assign last_word = widx_q == cnt_q - 1'b1;

  imem_loader_word_assembler u_asm (
    .clk        (clk),
    .rst        (rst),
    .clr        (state_q == LD_COUNT && xfer),
    .en         (state_q == LD_DATA && xfer),
    .din        (in_data),
    .word       (word),
    .word_ready (word_ready)
  );

  // Next-state and registered-output logic for the load sequence.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    widx_d      = widx_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    hold_d      = hold_q;
    done_d      = done_q;
    err_d       = err_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    chk_d       = chk_q;
`endif
    case (state_q)
      LD_IDLE, LD_DONE, LD_ERR: begin
        if (start) begin
          state_d = LD_COUNT;
          hold_d  = 1'b1;
          done_d  = 1'b0;
          err_d   = 1'b0;
        end
      end
      LD_COUNT: begin
        if (xfer && bad_cnt) begin
          state_d = LD_ERR;
          err_d   = 1'b1;
          hold_d  = 1'b0;
        end else if (xfer) begin
          state_d = LD_DATA;
          cnt_d   = (ADDR_W+1)'(in_data);
          widx_d  = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
          chk_d   = '0;
`endif
        end
      end
      LD_DATA: begin
        if (xfer) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          chk_d = chk_q ^ in_data;
`endif
          if (word_ready) begin
            mem_we_d    = 1'b1;
            mem_addr_d  = widx_q[ADDR_W-1:0];
            mem_wdata_d = word;
            widx_d      = widx_q + 1'b1;
            if (last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
              state_d = LD_CHECK;
`else
              state_d = LD_DONE;
              done_d  = 1'b1;
              hold_d  = 1'b0;
`endif
            end
          end
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      LD_CHECK: begin
        if (xfer) begin
          state_d = in_data == chk_q ? LD_DONE : LD_ERR;
          done_d  = in_data == chk_q;
          err_d   = in_data != chk_q;
          hold_d  = 1'b0;
        end
      end
`endif
      default: state_d = LD_IDLE;
    endcase
  end

  // All loader state and outputs update together; reset abandons any load in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= LD_IDLE;
      cnt_q       <= '0;
      widx_q      <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      hold_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      chk_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      widx_q      <= widx_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      hold_q      <= hold_d;
      done_q      <= done_d;
      err_q       <= err_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      chk_q       <= chk_d;
`endif
    end
  end

  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign cpu_hold  = hold_q;
  assign done      = done_q;
  assign error     = err_q;
endmodule
